// File: rtl/pwm_dac.sv
// PWM DAC: latches one clamped code per window and drives a registered PWM pin,
// acting as sample-rate master via next_sample. Define PWM_DAC_CENTER_ALIGN_EN for centre-aligned pulses.
module pwm_dac #(
  parameter int CYCLES_PER_WINDOW = 1024,
  parameter int CODE_WIDTH        = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [CODE_WIDTH-1:0] code,
  output logic                  next_sample,
  output logic                  window_start,
  output logic                  pwm
);

  localparam int W     = CYCLES_PER_WINDOW;
  localparam int CNT_W = $clog2(W);
  localparam int Q_W   = CNT_W + 1;
  localparam int EXT_W = ((CODE_WIDTH > Q_W) ? CODE_WIDTH : Q_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] CNT_NS   = CNT_W'(W - 2);

  // Saturate the requested duty to the window length (full-on at W).
  function automatic logic [Q_W-1:0] clamp_code(input logic [CODE_WIDTH-1:0] raw);
    logic [EXT_W-1:0] ext;
    ext = EXT_W'(raw);
    if (ext >= EXT_W'(W)) return Q_W'(W);
    else                  return Q_W'(ext);
  endfunction

  logic [CNT_W-1:0] count;
  logic [Q_W-1:0]   code_q;
  logic [Q_W-1:0]   code_c;
  logic             latch_en;
  logic             pwm_next;

  assign code_c   = clamp_code(code);
  assign latch_en = !enable || (count == CNT_LAST);

`ifdef PWM_DAC_CENTER_ALIGN_EN
  logic [Q_W-1:0] start_q;
  logic [Q_W-1:0] start_c;
  logic [Q_W-1:0] count_x;

  assign start_c  = (Q_W'(W) - code_c) >> 1;
  assign count_x  = {1'b0, count};
  assign pwm_next = enable && (count_x >= start_q) && (count_x < start_q + code_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        start_q <= '0;
    else if (latch_en) start_q <= start_c;
  end
`else
  assign pwm_next = enable && ({1'b0, count} < code_q);
`endif

  // Window counter and per-window code latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      code_q <= '0;
    end else begin
      if (!enable || count == CNT_LAST) count <= '0;
      else                              count <= count + CNT_W'(1);
      if (latch_en) code_q <= code_c;
    end
  end

  // Registered compare output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm <= 1'b0;
    else        pwm <= pwm_next;
  end

  assign next_sample  = rst_n && enable && (count == CNT_NS);
  assign window_start = rst_n && enable && (count == '0);

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac at W=16: per-window PWM masks and strobe timing
// checked against a window-level reference computed from the duty rules.
module tb_pwm_dac;

  localparam int W  = 16;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [CW-1:0] code;
  logic [CW-1:0] up_code;
  logic          next_sample;
  logic          window_start;
  logic          pwm;

  int n_checks = 0;
  int n_pass   = 0;

  pwm_dac #(.CYCLES_PER_WINDOW(W), .CODE_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .code(code),
    .next_sample(next_sample), .window_start(window_start), .pwm(pwm)
  );

  always #5 clk = ~clk;

  // Expected PWM samples for one window: bit k is pwm on the clock after count k.
  function automatic logic [W-1:0] exp_mask(input int unsigned req);
    int c;
    int s;
    logic [W-1:0] m;
    c = (req >= W) ? W : int'(req);
`ifdef PWM_DAC_CENTER_ALIGN_EN
    s = (W - c) / 2;
`else
    s = 0;
`endif
    for (int i = 0; i < W; i++) m[i] = (i >= s) && (i < s + c);
    return m;
  endfunction

  task automatic set_code(input logic [CW-1:0] v);
    code    = v;
    up_code = v;
  endtask

  // Advance to the next negedge where window_start is high.
  task automatic sync_window(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge clk);
      if (window_start === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Called at the negedge of a window_start cycle; ends at the next one.
  // Upstream applies up_code when it sees next_sample; chg_at forces a raw code change.
  task automatic measure(input int chg_at, input logic [CW-1:0] chg_val,
                         output logic [W-1:0] bits, output bit strobe_ok);
    strobe_ok = (next_sample === 1'b0);
    bits = '0;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      bits[k-1] = pwm;
      if (k < W) begin
        if (window_start !== 1'b0) strobe_ok = 1'b0;
        if (next_sample !== ((k == W - 2) ? 1'b1 : 1'b0)) strobe_ok = 1'b0;
      end else if (window_start !== 1'b1 || next_sample !== 1'b0) begin
        strobe_ok = 1'b0;
      end
      if (next_sample === 1'b1) code = up_code;
      if (k == chg_at) code = chg_val;
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] bits;
    bit ok;
    #1;
    n_checks++;
    if ({pwm, next_sample, window_start} !== 3'b000)
      $display("FAIL reset_init outputs=%b required=000", {pwm, next_sample, window_start});
    else n_pass++;
    @(negedge clk);
    set_code(10'd5);
    enable = 1'b1;
    rst_n  = 1'b1;
    #1;
    n_checks++;
    if (window_start !== 1'b1) $display("FAIL reset_release_ws got=%b required=1", window_start);
    else n_pass++;
    measure(-1, '0, bits, ok);
    n_checks++;
    if (bits !== exp_mask(0) || !ok) $display("FAIL reset_first_window got=%b strobes_ok=%0d required=%b", bits, ok, exp_mask(0));
    else n_pass++;
    measure(-1, '0, bits, ok);
    n_checks++;
    if (bits !== exp_mask(5) || !ok) $display("FAIL reset_second_window got=%b strobes_ok=%0d required=%b", bits, ok, exp_mask(5));
    else n_pass++;
    // mid-window asynchronous reset while the pulse is high
    repeat (3) @(negedge clk);
`ifdef PWM_DAC_CENTER_ALIGN_EN
    repeat (4) @(negedge clk);
`endif
    n_checks++;
    if (pwm !== 1'b1) $display("FAIL reset_pre_pwm got=%b required=1", pwm);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pwm, next_sample, window_start} !== 3'b000 || dut.count !== 4'd0)
      $display("FAIL reset_async outputs=%b count=%0d required=000 count=0",
               {pwm, next_sample, window_start}, dut.count);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({pwm, next_sample, window_start} !== 3'b000)
      $display("FAIL reset_held outputs=%b required=000", {pwm, next_sample, window_start});
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (window_start !== 1'b1) $display("FAIL reset_rerelease_ws got=%b required=1", window_start);
    else n_pass++;
    measure(-1, '0, bits, ok);
    n_checks++;
    if (bits !== exp_mask(0) || !ok) $display("FAIL reset_post_window0 got=%b strobes_ok=%0d required=%b", bits, ok, exp_mask(0));
    else n_pass++;
    measure(-1, '0, bits, ok);
    n_checks++;
    if (bits !== exp_mask(5) || !ok) $display("FAIL reset_post_window1 got=%b strobes_ok=%0d required=%b", bits, ok, exp_mask(5));
    else n_pass++;
  endtask

  task automatic test_duty(input logic [CW-1:0] v, input string name);
    logic [W-1:0] bits;
    bit ok;
    set_code(v);
    sync_window(ok);
    n_checks++;
    if (!ok) begin
      $display("FAIL %s_sync no window_start within %0d cycles", name, 4 * W);
      return;
    end
    n_pass++;
    measure(-1, '0, bits, ok);
    for (int n = 0; n < 2; n++) begin
      measure(-1, '0, bits, ok);
      n_checks++;
      if (bits !== exp_mask(v) || !ok)
        $display("FAIL %s_window%0d got=%b strobes_ok=%0d required=%b", name, n, bits, ok, exp_mask(v));
      else n_pass++;
    end
  endtask

  task automatic test_mid_change();
    logic [W-1:0] bits;
    bit ok;
    set_code(10'd5);
    sync_window(ok);
    measure(-1, '0, bits, ok);
    up_code = 10'd9;
    measure(3, 10'd9, bits, ok);
    n_checks++;
    if (bits !== exp_mask(5) || !ok) $display("FAIL mid_change_current got=%b strobes_ok=%0d required=%b", bits, ok, exp_mask(5));
    else n_pass++;
    measure(-1, '0, bits, ok);
    n_checks++;
    if (bits !== exp_mask(9) || !ok) $display("FAIL mid_change_next got=%b strobes_ok=%0d required=%b", bits, ok, exp_mask(9));
    else n_pass++;
  endtask

  task automatic test_enable_toggle();
    logic [W-1:0] bits;
    bit ok;
    bit idle_ok;
    set_code(10'd12);
    sync_window(ok);
    measure(-1, '0, bits, ok);
    repeat (7) @(negedge clk);
    n_checks++;
    if (pwm !== 1'b1) $display("FAIL en_pre_pwm got=%b required=1", pwm);
    else n_pass++;
    enable = 1'b0;
    set_code(10'd9);
    @(negedge clk);
    n_checks++;
    if (pwm !== 1'b0 || dut.count !== 4'd0)
      $display("FAIL en_drop pwm=%b count=%0d required pwm=0 count=0", pwm, dut.count);
    else n_pass++;
    idle_ok = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (pwm !== 1'b0 || next_sample !== 1'b0 || window_start !== 1'b0) idle_ok = 1'b0;
    end
    n_checks++;
    if (!idle_ok) $display("FAIL en_idle activity seen while disabled, required none");
    else n_pass++;
    enable = 1'b1;
    #1;
    n_checks++;
    if (window_start !== 1'b1) $display("FAIL en_restart_ws got=%b required=1", window_start);
    else n_pass++;
    measure(-1, '0, bits, ok);
    n_checks++;
    if (bits !== exp_mask(9) || !ok) $display("FAIL en_restart_window got=%b strobes_ok=%0d required=%b", bits, ok, exp_mask(9));
    else n_pass++;
    repeat (W - 2) @(negedge clk);
    n_checks++;
    if (next_sample !== 1'b1) $display("FAIL en_ns_before got=%b required=1", next_sample);
    else n_pass++;
    enable = 1'b0;
    #1;
    n_checks++;
    if (next_sample !== 1'b0) $display("FAIL en_ns_comb_drop got=%b required=0", next_sample);
    else n_pass++;
    @(negedge clk);
    enable = 1'b1;
    #1;
    n_checks++;
    if (window_start !== 1'b1) $display("FAIL en_reraise_ws got=%b required=1", window_start);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] bits;
    bit ok;
    int unsigned expc;
    set_code(CW'($urandom_range(0, W + 2)));
    sync_window(ok);
    measure(-1, '0, bits, ok);
    expc = code;
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 4) == 0) up_code = CW'($urandom_range(0, 1023));
      else                           up_code = CW'($urandom_range(0, W + 2));
      measure(-1, '0, bits, ok);
      n_checks++;
      if (bits !== exp_mask(expc) || !ok)
        $display("FAIL random_window%0d code=%0d got=%b strobes_ok=%0d required=%b", n, expc, bits, ok, exp_mask(expc));
      else n_pass++;
      expc = up_code;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    set_code('0);
    test_reset();
    test_duty(10'd5, "steady5");
    test_duty(10'd6, "steady6");
    test_duty(10'd0, "zero");
    test_duty(10'd16, "full16");
    test_duty(10'd1000, "clamp1000");
    test_duty(10'd1, "one");
    test_mid_change();
    test_enable_toggle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
